// File: rtl/scan_voltmeter_pkg.sv
// Shared types and widths for the scanning voltmeter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: datapath width DW, ADC mux address width ADDR_W, scan FSM state enum.
package scan_voltmeter_pkg;

  localparam int DW     = 12;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    STORE,
    NEXT
  } state_t;

endpackage

// File: rtl/scan_avg_accum.sv
// Sums 2^AVG_LOG2 ADC samples and presents the truncated mean.
// Latency: avg reflects a sample one cycle after add.
// Backpressure: none; add/clr are strobes from the scan FSM, clr wins over add.
// Ports: clk, rst (sync, active low), clr, add, din[DW] -> last (next add completes the set), avg[DW].
module scan_avg_accum
  import scan_voltmeter_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add,
  input  logic [DW-1:0] din,
  output logic          last,
  output logic [DW-1:0] avg
);

  localparam int AW = DW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= acc + AW'(din);
      cnt <= cnt + CW'(1);
    end
  end

  // The accumulator is exactly DW+AVG_LOG2 wide, so its top DW bits are the
  // sum shifted right by AVG_LOG2 (truncating division by the sample count).
  assign last = (cnt == CNT_LAST);
  assign avg  = acc[AW-1:AVG_LOG2];

endmodule

// File: rtl/scan_voltmeter.sv
// Scans CH_NUM ADC channels, averages 2^AVG_LOG2 samples each, holds per-channel results (optional peak hold).
// Latency: rd_data/rd_valid/peak_data one cycle after sel_ch or result change; frame_done one cycle after the last channel's NEXT.
// Backpressure: none; ADC paced by adc_start/adc_busy, re-issued if busy never rises within TIMEOUT cycles.
// Ports: clk, rst (sync, active low), scan_en, sel_ch, peak_clr | adc_start, adc_addr, adc_busy, adc_data |
//        rd_data, rd_valid, frame_done, peak_data. Define PEAK_HOLD_EN to build the peak-hold registers.
module scan_voltmeter
  import scan_voltmeter_pkg::*;
#(
  parameter int CH_NUM   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] sel_ch,
  input  logic              peak_clr,
  output logic              adc_start,
  output logic [ADDR_W-1:0] adc_addr,
  input  logic              adc_busy,
  input  logic [DW-1:0]     adc_data,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              frame_done,
  output logic [DW-1:0]     peak_data
);

  localparam int NSLOT = 1 << ADDR_W;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]   CH_LIM   = (ADDR_W + 1)'(CH_NUM);
  localparam logic [ADDR_W-1:0] CH_LAST  = ADDR_W'(CH_NUM - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT);

  state_t            state;
  logic [ADDR_W-1:0] ch;
  logic [ADDR_W-1:0] ch_inc;
  logic [TW-1:0]     tmo_cnt;

  // Storage is sized for the full address space; slots at or above CH_NUM
  // are never written and never read out.
  logic [DW-1:0]     result [NSLOT];
  logic [NSLOT-1:0]  valid;

  logic              acc_clr;
  logic              acc_add;
  logic              acc_last;
  logic [DW-1:0]     acc_avg;
  logic              sel_ok;
  logic              store_sel;

  // A partial accumulation is discarded by passing through IDLE.
  assign acc_clr   = (state == IDLE) || (state == STORE);
  assign acc_add   = (state == WAIT_DONE) && !adc_busy && scan_en;
  assign ch_inc    = (ch == CH_LAST) ? '0 : ch + ADDR_W'(1);
  assign sel_ok    = ({1'b0, sel_ch} < CH_LIM);
  assign store_sel = (state == STORE) && (ch == sel_ch);

  scan_avg_accum #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .add  (acc_add),
    .din  (adc_data),
    .last (acc_last),
    .avg  (acc_avg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ch         <= '0;
      tmo_cnt    <= '0;
      adc_start  <= 1'b0;
      adc_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      adc_start  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scan_en) begin
            state     <= ISSUE;
            ch        <= '0;
            adc_start <= 1'b1;
            adc_addr  <= '0;
          end
        end
        ISSUE: begin
          state   <= WAIT_BUSY;
          tmo_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (adc_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Converter never acknowledged: nothing is outstanding, so a
            // retry is safe; if scanning was stopped meanwhile, just leave.
            if (scan_en) begin
              state     <= ISSUE;
              adc_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!adc_busy) begin
            if (!scan_en) begin
              state <= IDLE;
            end else if (acc_last) begin
              state <= STORE;
            end else begin
              state     <= ISSUE;
              adc_start <= 1'b1;
            end
          end
        end
        STORE: begin
          state <= NEXT;
        end
        NEXT: begin
          ch         <= ch_inc;
          frame_done <= (ch == CH_LAST);
          if (scan_en) begin
            state     <= ISSUE;
            adc_start <= 1'b1;
            adc_addr  <= ch_inc;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < NSLOT; i++) result[i] <= '0;
    end else if (state == STORE) begin
      result[ch] <= acc_avg;
      valid[ch]  <= 1'b1;
    end
  end

  // Bypass the STORE write so a freshly selected channel shows its new value
  // on the same edge the result register takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (!sel_ok) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (store_sel) begin
      rd_data  <= acc_avg;
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= result[sel_ch];
      rd_valid <= valid[sel_ch];
    end
  end

`ifdef PEAK_HOLD_EN
  logic [DW-1:0] peak [NSLOT];
  logic [DW-1:0] peak_sel_nxt;

  // Next-state of the selected peak slot, mirroring the write priority below.
  always_comb begin
    peak_sel_nxt = peak[sel_ch];
    if (peak_clr) begin
      peak_sel_nxt = '0;
    end else if (store_sel && (acc_avg > peak[sel_ch])) begin
      peak_sel_nxt = acc_avg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) peak[i] <= '0;
      peak_data <= '0;
    end else begin
      if ((state == STORE) && (acc_avg > peak[ch])) begin
        peak[ch] <= acc_avg;
      end
      // Written last so a clear overrides a same-cycle update of that slot.
      if (peak_clr && sel_ok) begin
        peak[sel_ch] <= '0;
      end
      peak_data <= sel_ok ? peak_sel_nxt : '0;
    end
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_data       = '0;
`endif

endmodule
